regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file for the pipelined core: 2 async read ports, 1 sync write port.
//  Adds a per-register pending-write scoreboard: issue marks rd busy, writeback clears it.
//  Gives per-read-port ready flags to the decode/hazard stage. Reg 0 is hard-wired zero.
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  number of architectural registers (power of 2, >=2)
//  AW      $clog2(NREGS)  register address width (derived; do not override)
// PORTS
//  clk         in   1     single clock; all state updates on rising edge
//  rst         in   1     synchronous, active-high reset
//  we          in   1     writeback valid
//  waddr       in   AW    writeback destination
//  wdata       in   XLEN  writeback data
//  raddr1      in   AW    read port 1 address
//  raddr2      in   AW    read port 2 address
//  rdata1      out  XLEN  read port 1 data (combinational)
//  rdata2      out  XLEN  read port 2 data (combinational)
//  rdy1        out  1     raddr1 has no pending write (or it is forwarded this cycle)
//  rdy2        out  1     same, for raddr2
//  issue_valid in   1     instruction issued that will write issue_rd
//  issue_rd    in   AW    destination of issued instruction
//  flush       in   1     pipeline flush: drop all pending-write marks
//  busy_any    out  1     OR of all scoreboard bits (registered state, combinational OR)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all registers <= 0, all busy bits <= 0; dominates every other input.
//  - Reset mid-operation: in-flight we/issue in that cycle are discarded.
//  - Outputs after reset: rdata*=0, rdy*=1, busy_any=0.
//  - Read: rdataN = (raddrN==0) ? 0 : reg[raddrN]; zero latency, no clock.
//  - Write: at posedge, if we && waddr!=0 then reg[waddr] <= wdata; writes to 0 ignored.
//  - Scoreboard update at posedge, in priority order (later wins):
//    1) we && waddr!=0        -> busy[waddr] <= 0
//    2) flush                 -> all busy <= 0
//    3) issue_valid && issue_rd!=0 -> busy[issue_rd] <= 1
//  - Simultaneous writeback and issue to the same reg: busy ends 1 (new producer wins).
//  - Issue to an already-busy reg (WAW) is legal; the bit stays 1 and the first writeback clears it.
//  - flush does not alter register contents; same-cycle we still writes data.
//  - busy[0] is never set; rdyN is always 1 when raddrN==0.
//  - rdyN = !busy[raddrN] (before the same-cycle update), subject to the bypass rule below.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//  - if we && waddr!=0 && waddr==raddrN, then rdataN=wdata and rdyN=1 in the same cycle.
//  - This is write-through forwarding, so decode needs no extra stall cycle.
//  REGFILE_BYPASS_EN undefined:
//  - rdataN returns the old reg value and rdyN stays 0 that cycle.
//  - New value and rdyN=1 appear the next cycle.
// STRUCTURE
//  - Shared package/include rv_defs:
//    - XLEN default
//    - NREGS default
//    - ZERO_REG=0 constant
//    - AW derivation macro
//  - One sub-module regfile_scoreboard:
//    - contains the busy vector, issue/wb/flush priority logic and busy_any
//    - ports: clk, rst, set_en, set_idx, clr_en, clr_idx, flush, q_idx1, q_idx2, busy1, busy2, busy_any
//  - Storage array and read/bypass muxing stay in the top module.
// TESTING
//  1. Reset: write regs 1..31, assert rst 1 cycle -> every raddr reads 0, rdy1=rdy2=1, busy_any=0.
//  2. x0: we=1 waddr=0 wdata=32'hDEADBEEF; issue_rd=0 -> raddr1=0 reads 0, rdy1=1, busy_any=0.
//  3. Hazard: issue_rd=5, next cycle raddr1=5 -> rdy1=0;
//     then we waddr=5 wdata=32'h1234 -> bypass build: rdata1=0x1234, rdy1=1 that cycle;
//     non-bypass build: rdy1=0 that cycle, rdata1=0x1234 and rdy1=1 the next cycle.
//  4. Same-cycle wb+issue: busy[7]=1; we waddr=7 and issue_rd=7 together -> next cycle rdy(7)=0, data updated.
//  5. Flush: busy regs 3,9; flush=1 with issue_rd=4 -> next cycle only reg 4 busy, regs 3/9 data unchanged.
//  6. Reset mid-op: issue_rd=6 and we waddr=6 wdata=5 in the same cycle as rst=1 -> reg6=0, busy_any=0.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared register-file constants: default widths, the hard-wired zero register index, address-width helper.
// No logic or latency of its own.
// No flow control; pure definitions.
package regfile_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    function automatic int addr_w(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Core-side bundle for the register file: writeback, two read ports, issue and flush, plus status.
// Reads are combinational; writeback/issue/flush take effect at the next clock edge.
// No backpressure; decode stalls on the rdy flags.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) ();
    localparam int AW = addr_w(NREGS);

    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr1;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            rdy1;
    logic            rdy2;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            flush;
    logic            busy_any;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, issue_valid, issue_rd, flush,
        input  rdata1, rdata2, rdy1, rdy2, busy_any
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, issue_valid, issue_rd, flush,
        output rdata1, rdata2, rdy1, rdy2, busy_any
    );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback or flush.
// Busy queries are combinational on the registered vector; updates land at the clock edge.
// No backpressure; issue to an already-busy register simply keeps the bit set.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic          flush,
    input  logic [AW-1:0] q_idx1,
    input  logic [AW-1:0] q_idx2,
    output logic          busy1,
    output logic          busy2,
    output logic          busy_any
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Later steps override earlier ones so a same-cycle issue beats writeback and flush.
    always_comb begin
        busy_d = busy_q;
        if (clr_en && clr_idx != AW'(ZERO_REG)) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (set_en && set_idx != AW'(ZERO_REG)) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1    = busy_q[q_idx1];
    assign busy2    = busy_q[q_idx2];
    assign busy_any = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file, 2 async read / 1 sync write, reg 0 hard-wired zero, with pending-write scoreboard.
// Reads zero-latency; writes visible next cycle (same cycle when REGFILE_BYPASS_EN is defined).
// No backpressure; rdy1/rdy2 tell decode whether the read operand is final.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = addr_w(NREGS)
) (
    input logic        clk,
    input logic        rst,
    regfile_sb_if.slave rf
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;
    logic            busy1;
    logic            busy2;
    logic            bp1;
    logic            bp2;

    assign wr_en = rf.we && (rf.waddr != AW'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rf.waddr] <= rf.wdata;
        end
    end

    regfile_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (rf.issue_valid),
        .set_idx  (rf.issue_rd),
        .clr_en   (rf.we),
        .clr_idx  (rf.waddr),
        .flush    (rf.flush),
        .q_idx1   (rf.raddr1),
        .q_idx2   (rf.raddr2),
        .busy1    (busy1),
        .busy2    (busy2),
        .busy_any (rf.busy_any)
    );

`ifdef REGFILE_BYPASS_EN
    // Write-through forwarding: the writeback in flight this cycle is the operand decode sees.
    assign bp1 = wr_en && (rf.waddr == rf.raddr1);
    assign bp2 = wr_en && (rf.waddr == rf.raddr2);
`else
    assign bp1 = 1'b0;
    assign bp2 = 1'b0;
`endif

    always_comb begin
        rf.rdata1 = regs_q[rf.raddr1];
        rf.rdata2 = regs_q[rf.raddr2];
        if (bp1) rf.rdata1 = rf.wdata;
        if (bp2) rf.rdata2 = rf.wdata;
        if (rf.raddr1 == AW'(ZERO_REG)) rf.rdata1 = '0;
        if (rf.raddr2 == AW'(ZERO_REG)) rf.rdata2 = '0;
    end

    assign rf.rdy1 = (rf.raddr1 == AW'(ZERO_REG)) || !busy1 || bp1;
    assign rf.rdy2 = (rf.raddr2 == AW'(ZERO_REG)) || !busy2 || bp2;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios then randomized traffic against an array-based model.
// Works for both the default and the REGFILE_BYPASS_EN build.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) rf ();
    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (.clk(clk), .rst(rst), .rf(rf));

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic fwd_hit(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        return rf.we && rf.waddr != 0 && rf.waddr == a;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (fwd_hit(a)) return rf.wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_rdy(input logic [AW-1:0] a);
        if (a == 0 || fwd_hit(a)) return 1'b1;
        return !m_busy[a];
    endfunction

    function automatic logic exp_busy_any();
        for (int i = 0; i < NREGS; i++) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_model(input string tag);
        #1;
        chk({tag, "_rdata1"}, 64'(rf.rdata1), 64'(exp_rdata(rf.raddr1)));
        chk({tag, "_rdata2"}, 64'(rf.rdata2), 64'(exp_rdata(rf.raddr2)));
        chk({tag, "_rdy1"}, 64'(rf.rdy1), 64'(exp_rdy(rf.raddr1)));
        chk({tag, "_rdy2"}, 64'(rf.rdy2), 64'(exp_rdy(rf.raddr2)));
        chk({tag, "_busy_any"}, 64'(rf.busy_any), 64'(exp_busy_any()));
    endtask

    // Check current outputs, clock once, then advance the model with the inputs that were applied.
    task automatic tick(input string tag);
        check_model(tag);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (rf.we && rf.waddr != 0) begin
                m_regs[rf.waddr] = rf.wdata;
                m_busy[rf.waddr] = 1'b0;
            end
            if (rf.flush) for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
            if (rf.issue_valid && rf.issue_rd != 0) m_busy[rf.issue_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst            = 1'b0;
        rf.we          = 1'b0;
        rf.waddr       = '0;
        rf.wdata       = '0;
        rf.issue_valid = 1'b0;
        rf.issue_rd    = '0;
        rf.flush       = 1'b0;
    endtask

    task automatic do_issue(input logic [AW-1:0] rd);
        idle();
        rf.issue_valid = 1'b1;
        rf.issue_rd    = rd;
        tick("issue");
        idle();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        idle();
        rf.we    = 1'b1;
        rf.waddr = a;
        rf.wdata = d;
        tick("write");
        idle();
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NREGS - 1));
    endfunction

    initial begin
        idle();
        rf.raddr1 = '0;
        rf.raddr2 = '0;
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 'x;
            m_busy[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        @(negedge clk);
        idle();
        check_model("post_reset");

        // Reset clears a fully written file.
        for (int i = 1; i < NREGS; i++) do_write(AW'(i), $urandom() | 32'h1);
        do_issue(5'd12);
        rst = 1'b1;
        tick("reset_assert");
        idle();
        for (int i = 0; i < NREGS; i++) begin
            rf.raddr1 = AW'(i);
            rf.raddr2 = AW'(NREGS - 1 - i);
            #1;
            chk("rst_rdata1", 64'(rf.rdata1), 64'h0);
            chk("rst_rdata2", 64'(rf.rdata2), 64'h0);
            chk("rst_rdy1", 64'(rf.rdy1), 64'h1);
            chk("rst_rdy2", 64'(rf.rdy2), 64'h1);
        end
        chk("rst_busy_any", 64'(rf.busy_any), 64'h0);
        @(negedge clk);

        // x0 stays zero and never goes busy.
        rf.we = 1'b1; rf.waddr = '0; rf.wdata = 32'hDEADBEEF;
        rf.issue_valid = 1'b1; rf.issue_rd = '0; rf.raddr1 = '0;
        tick("x0");
        idle();
        #1;
        chk("x0_rdata1", 64'(rf.rdata1), 64'h0);
        chk("x0_rdy1", 64'(rf.rdy1), 64'h1);
        chk("x0_busy_any", 64'(rf.busy_any), 64'h0);
        @(negedge clk);

        // RAW hazard on x5.
        do_issue(5'd5);
        rf.raddr1 = 5'd5;
        #1;
        chk("haz_rdy1_busy", 64'(rf.rdy1), 64'h0);
        @(negedge clk);
        rf.we = 1'b1; rf.waddr = 5'd5; rf.wdata = 32'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("haz_fwd_rdata1", 64'(rf.rdata1), 64'h1234);
        chk("haz_fwd_rdy1", 64'(rf.rdy1), 64'h1);
`else
        chk("haz_wb_rdata1", 64'(rf.rdata1), 64'h0);
        chk("haz_wb_rdy1", 64'(rf.rdy1), 64'h0);
`endif
        tick("haz_wb");
        idle();
        #1;
        chk("haz_next_rdata1", 64'(rf.rdata1), 64'h1234);
        chk("haz_next_rdy1", 64'(rf.rdy1), 64'h1);
        @(negedge clk);

        // Same-cycle writeback and re-issue of x7: new producer keeps it busy.
        do_issue(5'd7);
        rf.we = 1'b1; rf.waddr = 5'd7; rf.wdata = 32'h77;
        rf.issue_valid = 1'b1; rf.issue_rd = 5'd7;
        tick("wb_issue");
        idle();
        rf.raddr1 = 5'd7;
        #1;
        chk("wbiss_rdy1", 64'(rf.rdy1), 64'h0);
        chk("wbiss_rdata1", 64'(rf.rdata1), 64'h77);
        @(negedge clk);

        // Flush drops x3/x9 (and x7) while a same-cycle issue of x4 survives.
        do_write(5'd3, 32'h33);
        do_write(5'd9, 32'h99);
        do_issue(5'd3);
        do_issue(5'd9);
        rf.flush = 1'b1; rf.issue_valid = 1'b1; rf.issue_rd = 5'd4;
        tick("flush");
        idle();
        rf.raddr1 = 5'd3; rf.raddr2 = 5'd9;
        #1;
        chk("fl_rdy3", 64'(rf.rdy1), 64'h1);
        chk("fl_rdy9", 64'(rf.rdy2), 64'h1);
        chk("fl_data3", 64'(rf.rdata1), 64'h33);
        chk("fl_data9", 64'(rf.rdata2), 64'h99);
        rf.raddr1 = 5'd4; rf.raddr2 = 5'd7;
        #1;
        chk("fl_rdy4", 64'(rf.rdy1), 64'h0);
        chk("fl_rdy7", 64'(rf.rdy2), 64'h1);
        chk("fl_busy_any", 64'(rf.busy_any), 64'h1);
        @(negedge clk);

        // Reset wins over same-cycle issue and writeback.
        rst = 1'b1;
        rf.we = 1'b1; rf.waddr = 5'd6; rf.wdata = 32'h5;
        rf.issue_valid = 1'b1; rf.issue_rd = 5'd6;
        tick("rst_midop");
        idle();
        rf.raddr1 = 5'd6;
        #1;
        chk("rmid_rdata6", 64'(rf.rdata1), 64'h0);
        chk("rmid_busy_any", 64'(rf.busy_any), 64'h0);
        @(negedge clk);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            rf.we          = $urandom_range(0, 1);
            rf.waddr       = rnd_addr();
            rf.wdata       = $urandom();
            rf.issue_valid = $urandom_range(0, 1);
            rf.issue_rd    = rnd_addr();
            rf.flush       = ($urandom_range(0, 15) == 0);
            rf.raddr1      = rnd_addr();
            rf.raddr2      = rnd_addr();
            tick("rnd");
        end
        idle();
        check_model("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
